// File: rtl/emaxi_arb_pkg.sv
// emaxi_arb_pkg: shared FSM states, AW/W field layout and counter width for the emaxi write arbiter
package emaxi_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
  localparam int AW_BURST_LSB = 0;
  localparam int AW_SIZE_LSB = AW_BURST_LSB + 2;
  localparam int AW_LEN_LSB = AW_SIZE_LSB + 3;
  localparam int AW_ADDR_LSB = AW_LEN_LSB + 8;
  localparam int AW_W = AW_ADDR_LSB + 32;
  localparam int W_STRB_LSB = 0;
  localparam int W_DATA_LSB = W_STRB_LSB + 8;
  localparam int W_W = W_DATA_LSB + 64;
  localparam int CNT_W = 4;
endpackage

// File: rtl/emaxi_rr_pick.sv
// emaxi_rr_pick: first set request at or above ptr, wrapping to the lowest set request below it
module emaxi_rr_pick #(
  parameter int N = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int j = N - 1; j >= 0; j--) if (req[j] && IDX_W'(j) < ptr) idx = IDX_W'(j);
    for (int j = N - 1; j >= 0; j--) if (req[j] && IDX_W'(j) >= ptr) idx = IDX_W'(j);
    gnt = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/emaxi_wr_arbiter.sv
// emaxi_wr_arbiter: round-robin share of the emaxi AXI3 write channel, burst-locked grant,
// index-tagged IDs, B routed back by BID, outstanding writes capped at MAX_OUTST
module emaxi_wr_arbiter
  import emaxi_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = 12,
  parameter int MAX_OUTST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_awvalid,
  input  logic [N_REQ*AW_W-1:0]   req_aw,
  output logic [N_REQ-1:0]        req_awready,
  input  logic [N_REQ-1:0]        req_wvalid,
  input  logic [N_REQ*W_W-1:0]    req_w,
  input  logic [N_REQ-1:0]        req_wlast,
  output logic [N_REQ-1:0]        req_wready,
  output logic [N_REQ-1:0]        req_bvalid,
  output logic [1:0]              req_bresp,
  input  logic [N_REQ-1:0]        req_bready,
  output logic                    m_awvalid,
  output logic [AW_W-1:0]         m_aw,
  output logic [ID_W-1:0]         m_awid,
  input  logic                    m_awready,
  output logic                    m_wvalid,
  output logic [W_W-1:0]          m_w,
  output logic                    m_wlast,
  output logic [ID_W-1:0]         m_wid,
  input  logic                    m_wready,
  input  logic                    m_bvalid,
  input  logic [ID_W-1:0]         m_bid,
  input  logic [1:0]              m_bresp,
  output logic                    m_bready,
  output logic [CNT_W-1:0]        outst_cnt
);
  localparam int IDX_W = $clog2(N_REQ);
  state_t state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick_idx, bidx;
  logic [CNT_W-1:0] outst_cnt_q, outst_cnt_d;
  logic [N_REQ-1:0] pick_gnt, bsel;
  logic aw_hs, w_hs, b_hs, bid_ok, in_data;
  emaxi_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req(req_awvalid),
    .ptr(rr_ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  // Out-of-range BIDs are drained so a stray response can never stall emaxi
  always_comb begin
    bidx = m_bid[IDX_W-1:0];
    bid_ok = m_bid < ID_W'(N_REQ);
    bsel = bid_ok ? N_REQ'(1) << bidx : '0;
    req_bvalid = m_bvalid ? bsel : '0;
    req_bresp = m_bresp;
    m_bready = !bid_ok || |(req_bready & bsel);
    b_hs = m_bvalid && m_bready && bid_ok;
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    in_data = state_q == ST_DATA;
    m_awvalid = state_q == ST_ADDR;
    aw_hs = m_awvalid && m_awready;
    w_hs = in_data && req_wvalid[grant_q] && m_wready;
    m_aw = m_awvalid ? req_aw[grant_q*AW_W +: AW_W] : '0;
    m_awid = m_awvalid ? ID_W'(grant_q) : '0;
    req_awready = aw_hs ? N_REQ'(1) << grant_q : '0;
    m_wvalid = in_data && req_wvalid[grant_q];
    m_w = in_data ? req_w[grant_q*W_W +: W_W] : '0;
    m_wlast = in_data && req_wlast[grant_q];
    m_wid = in_data ? ID_W'(grant_q) : '0;
    req_wready = in_data && m_wready ? N_REQ'(1) << grant_q : '0;
    if (state_q == ST_IDLE && |pick_gnt && outst_cnt_q < CNT_W'(MAX_OUTST)) begin
      state_d = ST_ADDR;
      grant_d = pick_idx;
    end
    if (aw_hs) state_d = ST_DATA;
    if (w_hs && req_wlast[grant_q]) begin
      state_d = ST_IDLE;
      rr_ptr_d = grant_q == IDX_W'(N_REQ - 1) ? '0 : grant_q + 1'b1;
    end
    outst_cnt_d = aw_hs && !b_hs ? outst_cnt_q + 1'b1 :
                  b_hs && !aw_hs && outst_cnt_q != '0 ? outst_cnt_q - 1'b1 : outst_cnt_q;
    outst_cnt = outst_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
      outst_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      outst_cnt_q <= outst_cnt_d;
    end
  end
endmodule

// File: tb/tb_emaxi_wr_arbiter.sv
// tb_emaxi_wr_arbiter: directed scenarios on two shared-input instances (MAX_OUTST=2 and MAX_OUTST=4)
module tb_emaxi_wr_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_awvalid, req_wvalid, req_wlast, req_bready;
  logic [179:0] req_aw;
  logic [287:0] req_w;
  logic m_awready, m_wready, m_bvalid;
  logic [11:0] m_bid;
  logic [1:0] m_bresp;
  logic [3:0] req_awready, req_wready, req_bvalid, outst_cnt;
  logic [1:0] req_bresp;
  logic m_awvalid, m_wvalid, m_wlast, m_bready;
  logic [44:0] m_aw;
  logic [71:0] m_w;
  logic [11:0] m_awid, m_wid;
  logic [3:0] x_req_awready, x_req_wready, x_req_bvalid, x_outst_cnt;
  logic [1:0] x_req_bresp;
  logic x_m_awvalid, x_m_wvalid, x_m_wlast, x_m_bready;
  logic [44:0] x_m_aw;
  logic [71:0] x_m_w;
  logic [11:0] x_m_awid, x_m_wid;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  emaxi_wr_arbiter #(.N_REQ(4), .ID_W(12), .MAX_OUTST(2)) u_dut (
    .clk(clk), .rst(rst), .req_awvalid(req_awvalid), .req_aw(req_aw), .req_awready(req_awready),
    .req_wvalid(req_wvalid), .req_w(req_w), .req_wlast(req_wlast), .req_wready(req_wready),
    .req_bvalid(req_bvalid), .req_bresp(req_bresp), .req_bready(req_bready),
    .m_awvalid(m_awvalid), .m_aw(m_aw), .m_awid(m_awid), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_w(m_w), .m_wlast(m_wlast), .m_wid(m_wid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bid(m_bid), .m_bresp(m_bresp), .m_bready(m_bready), .outst_cnt(outst_cnt)
  );
  emaxi_wr_arbiter #(.N_REQ(4), .ID_W(12), .MAX_OUTST(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_awvalid(req_awvalid), .req_aw(req_aw), .req_awready(x_req_awready),
    .req_wvalid(req_wvalid), .req_w(req_w), .req_wlast(req_wlast), .req_wready(x_req_wready),
    .req_bvalid(x_req_bvalid), .req_bresp(x_req_bresp), .req_bready(req_bready),
    .m_awvalid(x_m_awvalid), .m_aw(x_m_aw), .m_awid(x_m_awid), .m_awready(m_awready),
    .m_wvalid(x_m_wvalid), .m_w(x_m_w), .m_wlast(x_m_wlast), .m_wid(x_m_wid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bid(m_bid), .m_bresp(m_bresp), .m_bready(x_m_bready), .outst_cnt(x_outst_cnt)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs;
    req_awvalid = '0; req_wvalid = '0; req_wlast = '0; req_bready = '0; req_aw = '0; req_w = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = '0; m_bresp = '0;
  endtask
  task automatic do_reset;
    rst = 1;
    clear_inputs();
    repeat (2) tick();
    rst = 0;
    tick();
  endtask
  // Drives one full burst for requester r on the MAX_OUTST=2 instance and reports what was seen
  task automatic burst(input int r, input int beats, output int gid, output int lat, output int nb,
                       output int last_at, output logic [44:0] aws, output logic [3:0] awr);
    gid = -1; lat = 0; nb = 0; last_at = 0; aws = '0; awr = '0;
    m_awready = 1; m_wready = 1;
    req_aw[r*45 +: 45] = {32'h1000_0000 + 32'(r), 8'(beats - 1), 3'd3, 2'd1};
    req_awvalid[r] = 1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (m_awvalid) begin
        gid = int'(m_awid); aws = m_aw; awr = req_awready;
        break;
      end
      lat++;
      tick();
    end
    if (gid < 0) begin
      req_awvalid[r] = 0;
      return;
    end
    tick();
    req_awvalid[r] = 0;
    for (int b = 0; b < beats; b++) begin
      req_wvalid[r] = 1;
      req_wlast[r] = b == beats - 1;
      req_w[r*72 +: 72] = {64'hD000_0000_0000_0000 + 64'(b), 8'hFF};
      #1;
      if (m_wvalid && m_wid == 12'(r) && req_wready[r]) nb++;
      if (m_wlast) last_at = nb;
      tick();
    end
    req_wvalid[r] = 0;
    req_wlast[r] = 0;
  endtask
  task automatic test_reset;
    clear_inputs();
    tick();
    n_cmp++; if ({m_awvalid, m_wvalid, m_bready, req_awready, req_wready, req_bvalid} !== '0) begin n_bad++; $display("FAIL reset_valids got %b want 0", {m_awvalid, m_wvalid, m_bready, req_awready, req_wready, req_bvalid}); end
    n_cmp++; if ({m_aw, m_awid, m_wid, m_w} !== '0) begin n_bad++; $display("FAIL reset_payload got %h want 0", {m_aw, m_awid, m_wid, m_w}); end
    n_cmp++; if (outst_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", outst_cnt); end
    rst = 0;
    tick();
  endtask
  task automatic test_single;
    int gid, lat, nb, la;
    logic [44:0] aws;
    logic [3:0] awr;
    do_reset();
    m_bresp = 2'b10;
    burst(0, 4, gid, lat, nb, la, aws, awr);
    n_cmp++; if (gid !== 0) begin n_bad++; $display("FAIL single_awid got %0d want 0", gid); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL single_aw_latency got %0d want 1", lat); end
    n_cmp++; if (aws !== {32'h1000_0000, 8'd3, 3'd3, 2'd1}) begin n_bad++; $display("FAIL single_aw got %h want %h", aws, {32'h1000_0000, 8'd3, 3'd3, 2'd1}); end
    n_cmp++; if (awr !== 4'b0001) begin n_bad++; $display("FAIL single_awready got %b want 0001", awr); end
    n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL single_beats got %0d want 4", nb); end
    n_cmp++; if (la !== 4) begin n_bad++; $display("FAIL single_wlast_beat got %0d want 4", la); end
    n_cmp++; if (outst_cnt !== 4'd1) begin n_bad++; $display("FAIL single_cnt_up got %0d want 1", outst_cnt); end
    m_bvalid = 1; m_bid = 12'd0; req_bready = 4'b0001;
    #1;
    n_cmp++; if (req_bvalid !== 4'b0001) begin n_bad++; $display("FAIL single_bvalid got %b want 0001", req_bvalid); end
    n_cmp++; if ({m_bready, req_bresp} !== 3'b110) begin n_bad++; $display("FAIL single_bready_bresp got %b want 110", {m_bready, req_bresp}); end
    tick();
    m_bvalid = 0; req_bready = '0;
    n_cmp++; if (outst_cnt !== 4'd0) begin n_bad++; $display("FAIL single_cnt_down got %0d want 0", outst_cnt); end
  endtask
  task automatic test_round_robin;
    int order[5] = '{-1, -1, -1, -1, -1};
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int ng = 0, beat = 0, cur = -1, nw = 0, hold_bad = 0;
    do_reset();
    m_awready = 1; m_wready = 1; req_wvalid = '1; req_bready = '1; m_bvalid = 1; m_bid = '0;
    req_awvalid = '1;
    for (int c = 0; c < 100 && nw < 5; c++) begin
      req_wlast = beat == 1 ? 4'hF : 4'h0;
      #1;
      if (m_awvalid && ng < 5) begin
        order[ng] = int'(m_awid); cur = int'(m_awid); ng++;
      end
      if (m_wvalid) begin
        if (m_wid != 12'(cur) || req_wready != 4'(1 << cur) || req_awready != 4'd0) hold_bad++;
        if (beat == 1) begin nw++; beat = 0; end else beat = 1;
      end
      if (nw == 5) req_awvalid = '0;
      tick();
    end
    req_awvalid = '0; req_wvalid = '0; req_wlast = '0; m_bvalid = 0; req_bready = '0;
    n_cmp++; if (nw !== 5) begin n_bad++; $display("FAIL rr_bursts_done got %0d want 5", nw); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (order[i] !== exp_order[i]) begin n_bad++; $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], exp_order[i]); end
    end
    n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL rr_grant_hold got %0d bad beats want 0", hold_bad); end
  endtask
  task automatic test_limit;
    int gid, lat, nb, la, seen = 0;
    logic [44:0] aws;
    logic [3:0] awr;
    do_reset();
    burst(1, 1, gid, lat, nb, la, aws, awr);
    burst(2, 1, gid, lat, nb, la, aws, awr);
    n_cmp++; if (outst_cnt !== 4'd2) begin n_bad++; $display("FAIL limit_cnt_full got %0d want 2", outst_cnt); end
    req_awvalid[3] = 1;
    repeat (6) begin
      tick();
      if (m_awvalid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL limit_blocked got %0d awvalid cycles want 0", seen); end
    m_bvalid = 1; m_bid = 12'd1; req_bready = 4'b0010;
    #1;
    n_cmp++; if ({req_bvalid, m_bready} !== 5'b00101) begin n_bad++; $display("FAIL limit_b_route got %b want 00101", {req_bvalid, m_bready}); end
    tick();
    m_bvalid = 0; req_bready = '0;
    #1;
    n_cmp++; if ({m_awvalid, outst_cnt} !== 5'b0_0001) begin n_bad++; $display("FAIL limit_after_b got %b want 00001", {m_awvalid, outst_cnt}); end
    tick();
    n_cmp++; if ({m_awvalid, m_awid} !== {1'b1, 12'd3}) begin n_bad++; $display("FAIL limit_regrant got %b/%0d want 1/3", m_awvalid, m_awid); end
    tick();
    req_awvalid = '0; req_wvalid[3] = 1; req_wlast[3] = 1;
    tick();
    req_wvalid = '0; req_wlast = '0;
  endtask
  task automatic test_simul;
    int gid, lat, nb, la;
    logic [44:0] aws;
    logic [3:0] awr;
    do_reset();
    burst(0, 1, gid, lat, nb, la, aws, awr);
    burst(1, 1, gid, lat, nb, la, aws, awr);
    n_cmp++; if (x_outst_cnt !== 4'd2) begin n_bad++; $display("FAIL simul_cnt_pre got %0d want 2", x_outst_cnt); end
    m_awready = 0; req_awvalid[2] = 1;
    tick();
    n_cmp++; if ({x_m_awvalid, x_m_awid} !== {1'b1, 12'd2}) begin n_bad++; $display("FAIL simul_grant got %b/%0d want 1/2", x_m_awvalid, x_m_awid); end
    m_awready = 1; m_bvalid = 1; m_bid = '0; req_bready = 4'b0001;
    tick();
    m_bvalid = 0; req_bready = '0; req_awvalid = '0;
    n_cmp++; if (x_outst_cnt !== 4'd2) begin n_bad++; $display("FAIL simul_cnt_hold got %0d want 2", x_outst_cnt); end
    n_cmp++; if (outst_cnt !== 4'd1) begin n_bad++; $display("FAIL simul_b_only_cnt got %0d want 1", outst_cnt); end
    req_wvalid[2] = 1; req_wlast[2] = 1;
    tick();
    req_wvalid = '0; req_wlast = '0;
  endtask
  task automatic test_bad_bid;
    m_bvalid = 1; m_bid = 12'd7; req_bready = '0;
    #1;
    n_cmp++; if ({m_bready, req_bvalid} !== 5'b10000) begin n_bad++; $display("FAIL badbid_route got %b want 10000", {m_bready, req_bvalid}); end
    tick();
    m_bvalid = 0; m_bid = '0;
    n_cmp++; if (outst_cnt !== 4'd1) begin n_bad++; $display("FAIL badbid_cnt got %0d want 1", outst_cnt); end
  endtask
  task automatic test_reset_mid;
    int gid, lat, nb, la;
    logic [44:0] aws;
    logic [3:0] awr;
    do_reset();
    burst(1, 1, gid, lat, nb, la, aws, awr);
    req_aw[2*45 +: 45] = {32'h2000_0000, 8'd3, 3'd3, 2'd1};
    req_awvalid[2] = 1;
    tick();
    tick();
    req_awvalid = '0; req_wvalid[2] = 1; req_wlast[2] = 0; req_w[2*72 +: 72] = {64'hABCD, 8'hFF};
    tick();
    tick();
    #1;
    n_cmp++; if ({m_wvalid, m_wid} !== {1'b1, 12'd2}) begin n_bad++; $display("FAIL midrst_in_data got %b/%0d want 1/2", m_wvalid, m_wid); end
    rst = 1;
    #1;
    n_cmp++; if ({m_awvalid, m_wvalid, m_wlast, req_awready, req_wready, m_wid, m_w, outst_cnt} !== '0) begin n_bad++; $display("FAIL midrst_outputs got %h want 0", {m_awvalid, m_wvalid, m_wlast, req_awready, req_wready, m_wid, m_w, outst_cnt}); end
    rst = 0;
    req_wvalid = '0;
    tick();
    req_awvalid = '1;
    #1;
    for (int c = 0; c < 10 && !m_awvalid; c++) tick();
    n_cmp++; if ({m_awvalid, m_awid} !== {1'b1, 12'd0}) begin n_bad++; $display("FAIL midrst_next_grant got %b/%0d want 1/0", m_awvalid, m_awid); end
    req_awvalid = '0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_limit();
    test_simul();
    test_bad_bid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
